red_pitaya_pulse_gen: RTL and testbench

//  Downstream consumer of red_pitaya_delay: takes its delayed trigger strobe and emits a

---
 rtl/red_pitaya_pulse_gen.sv | 189 ++++++++++++++++++
 tb/tb_red_pitaya_pulse_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_pulse_gen.sv
// -----------------------------------------------------------------------------
// red_pitaya_pulse_gen
//
// Purpose
//   Takes the delayed trigger strobe from red_pitaya_delay and emits a
//   programmable pulse train on pulse_o. Width, period and repeat count are
//   latched when a trigger is accepted. Width and period are counted in timing
//   ticks; a tick is one wrap of a DIV-cycle prescaler, which matches the
//   delay stage. Single clock domain (adc_clk_i).
//
// Parameters
//   DIV  clock cycles per timing tick (>= 1; 1 = raw clock cycles)
//   TW   width of the tick-count fields width_i / period_i
//   NW   width of the repeat-count field count_i
//
// Ports
//   adc_clk_i   in   1   clock
//   adc_rstn_i  in   1   synchronous active-low reset
//   arm_i       in   1   level; when high, the next trig_i starts a train
//   trig_i      in   1   single-cycle trigger strobe
//   width_i     in   TW  high time per pulse, ticks
//   period_i    in   TW  pulse start-to-start spacing, ticks
//   count_i     in   NW  pulses per train (0 is treated as 1)
//   abort_i     in   1   single-cycle; stops a running train at the next edge
//   invert_i    in   1   only with PULSE_GEN_INVERT_EN; 1 = idle high, pulse low
//   pulse_o     out  1   registered pulse output
//   busy_o      out  1   train in progress
//   done_o      out  1   single-cycle strobe at train end (normal or abort)
//   miss_o      out  1   single-cycle strobe: trig_i ignored while busy
//
// Configuration
//   PULSE_GEN_INVERT_EN  when defined, adds invert_i. It is latched at
//   acceptance and sets the idle level of pulse_o from then on. pulse_o still
//   resets to 0.
// -----------------------------------------------------------------------------
module red_pitaya_pulse_gen #(
  parameter int DIV = 100,
  parameter int TW  = 32,
  parameter int NW  = 16
) (
  input  logic          adc_clk_i,
  input  logic          adc_rstn_i,
  input  logic          arm_i,
  input  logic          trig_i,
  input  logic [TW-1:0] width_i,
  input  logic [TW-1:0] period_i,
  input  logic [NW-1:0] count_i,
  input  logic          abort_i,
`ifdef PULSE_GEN_INVERT_EN
  input  logic          invert_i,
`endif
  output logic          pulse_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          miss_o
);

  // Prescaler width; DIV=1 still needs a one-bit register that stays at 0.
  localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_pre;       // cycle within the current tick
  logic [TW-1:0] r_tick;      // tick within the current HIGH/LOW phase
  logic [TW-1:0] r_width;     // latched HIGH length, ticks
  logic [TW-1:0] r_low;       // latched LOW length, ticks (>= 1)
  logic [NW-1:0] r_count;     // latched pulse count (>= 1)
  logic [NW-1:0] r_emitted;   // pulses started so far in this train
  logic          r_idle_lvl;  // latched inactive level of pulse_o

  logic          w_inv_in;
  logic          w_accept;
  logic          w_tick;
  logic          w_phase_end;
  logic [TW-1:0] w_phase_len;
  logic [TW-1:0] w_low_in;
  logic [NW-1:0] w_count_in;

`ifdef PULSE_GEN_INVERT_EN
  assign w_inv_in = invert_i;
`else
  assign w_inv_in = 1'b0;
`endif

  // Abort wins over a trigger in the same cycle, so the trigger is dropped.
  assign w_accept = (r_state == S_IDLE) && trig_i && arm_i && !abort_i;

  // Normalise the configuration at latch time. A period no longer than the
  // width still gets one low tick, and a count of zero means one pulse.
  assign w_low_in   = (period_i > width_i) ? (period_i - width_i) : TW'(1);
  assign w_count_in = (count_i == '0) ? NW'(1) : count_i;

  assign w_tick = (r_pre == PRE_LAST);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_phase_len = r_low;
    if (r_state == S_HIGH) w_phase_len = r_width;
  end

  // The last cycle of the last tick of the current phase.
  assign w_phase_end = w_tick && (r_tick == (w_phase_len - 1'b1));

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the pre-edge values, whatever the statement order.
  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) begin
      r_state    <= S_IDLE;
      r_pre      <= '0;
      r_tick     <= '0;
      r_width    <= '0;
      r_low      <= '0;
      r_count    <= '0;
      r_emitted  <= '0;
      r_idle_lvl <= 1'b0;
      pulse_o    <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      miss_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      miss_o <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_idle_lvl <= w_inv_in;
            r_width    <= width_i;
            r_low      <= w_low_in;
            r_count    <= w_count_in;
            r_emitted  <= NW'(1);
            r_pre      <= '0;
            r_tick     <= '0;
            if (width_i == '0) begin
              // Zero width: the train completes at once and emits no pulse.
              pulse_o <= w_inv_in;
              done_o  <= 1'b1;
            end else begin
              r_state <= S_HIGH;
              busy_o  <= 1'b1;
              pulse_o <= ~w_inv_in;
            end
          end
        end

        default: begin
          // busy_o is still high on the edge where the train ends, so a
          // trigger in that cycle counts as missed; no same-cycle retrigger.
          miss_o <= trig_i;

          if (abort_i) begin
            r_state <= S_IDLE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            pulse_o <= r_idle_lvl;
          end else begin
            r_pre <= w_tick ? '0 : (r_pre + 1'b1);
            if (w_tick) r_tick <= w_phase_end ? '0 : (r_tick + 1'b1);

            if (w_phase_end) begin
              if (r_state == S_HIGH) begin
                r_state <= S_LOW;
                pulse_o <= r_idle_lvl;
              end else if (r_emitted == r_count) begin
                // The last pulse keeps its full period before the train ends.
                r_state <= S_IDLE;
                busy_o  <= 1'b0;
                done_o  <= 1'b1;
              end else begin
                // The next pulse starts right after LOW, with no gap cycle.
                r_state   <= S_HIGH;
                pulse_o   <= ~r_idle_lvl;
                r_emitted <= r_emitted + 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_red_pitaya_pulse_gen.sv
module tb_red_pitaya_pulse_gen;

  logic        clk = 1'b0;
  logic        rstn0, rstn1, arm;
  logic        trig0, trig1, abort0, abort1;
  logic [31:0] width, period;
  logic [15:0] count;
  logic        inv;
  logic        pulse0, busy0, done0, miss0;
  logic        pulse1, busy1, done1, miss1;

  int n_checks = 0;
  int n_errors = 0;

  // Statistics of one recording window; index i is the i-th cycle after the
  // edge that sampled the starting trigger.
  int n_hi, last_hi, n_rise, n_busy, last_busy, n_done, done_idx, n_miss;
  int rise_idx [8];
  int miss_idx [8];
  int last_raw;

  always #5 clk = ~clk;

  // Main DUT with DIV=4; the second has DIV=1 for the mid-train reset case.
  red_pitaya_pulse_gen #(.DIV(4), .TW(32), .NW(16)) u_dut (
    .adc_clk_i (clk),
    .adc_rstn_i(rstn0),
    .arm_i     (arm),
    .trig_i    (trig0),
    .width_i   (width),
    .period_i  (period),
    .count_i   (count),
    .abort_i   (abort0),
`ifdef PULSE_GEN_INVERT_EN
    .invert_i  (inv),
`endif
    .pulse_o   (pulse0),
    .busy_o    (busy0),
    .done_o    (done0),
    .miss_o    (miss0)
  );

  red_pitaya_pulse_gen #(.DIV(1), .TW(32), .NW(16)) u_dut1 (
    .adc_clk_i (clk),
    .adc_rstn_i(rstn1),
    .arm_i     (arm),
    .trig_i    (trig1),
    .width_i   (width),
    .period_i  (period),
    .count_i   (count),
    .abort_i   (abort1),
`ifdef PULSE_GEN_INVERT_EN
    .invert_i  (1'b0),
`endif
    .pulse_o   (pulse1),
    .busy_o    (busy1),
    .done_o    (done1),
    .miss_o    (miss1)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic set_cfg(input int w, input int p, input int c);
    width  = w;
    period = p;
    count  = 16'(c);
  endtask

  // Drives a starting trigger (and/or abort) for cycle 0, then records n
  // cycles. Trigger/abort/reset requests at step i are driven for cycle i.
  // cfg_at changes the config inputs mid-train. Must be called at a negedge.
  task automatic run_window(input bit sel, input int n, input int t0,
                            input int t1, input int t2, input int ab_at,
                            input int cfg_at, input int rst_at,
                            input bit start_trig, input bit start_abort,
                            input bit exp_inv);
    logic p, b, d, m, act, prev;
    n_hi = 0; last_hi = -1; n_rise = 0; n_busy = 0; last_busy = -1;
    n_done = 0; done_idx = -1; n_miss = 0; last_raw = -1;
    foreach (rise_idx[k]) begin rise_idx[k] = -1; miss_idx[k] = -1; end
    prev = 1'b0;
    if (sel) begin trig1 = start_trig; abort1 = start_abort; end
    else     begin trig0 = start_trig; abort0 = start_abort; end
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      p = sel ? pulse1 : pulse0;
      b = sel ? busy1  : busy0;
      d = sel ? done1  : done0;
      m = sel ? miss1  : miss0;
      act = p ^ exp_inv;
      last_raw = int'(p);
      if (act) begin n_hi++; last_hi = i; end
      if (act && !prev) begin
        if (n_rise < 8) rise_idx[n_rise] = i;
        n_rise++;
      end
      prev = act;
      if (b) begin n_busy++; last_busy = i; end
      if (d) begin
        if (n_done == 0) done_idx = i;
        n_done++;
      end
      if (m) begin
        if (n_miss < 8) miss_idx[n_miss] = i;
        n_miss++;
      end
      if (sel) begin
        trig1  = (i == t0) || (i == t1) || (i == t2);
        abort1 = (i == ab_at);
        rstn1  = (i != rst_at);
      end else begin
        trig0  = (i == t0) || (i == t1) || (i == t2);
        abort0 = (i == ab_at);
        rstn0  = (i != rst_at);
      end
      if (i == cfg_at) begin
        width  = width + 5;
        period = period + 3;
        count  = count + 16'd2;
      end
    end
    trig0 = 1'b0; trig1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0;
    rstn0 = 1'b1; rstn1 = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    int any_out;
    rstn0 = 1'b0; rstn1 = 1'b0; arm = 1'b1; inv = 1'b0;
    trig0 = 1'b0; trig1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0;
    set_cfg(3, 5, 1);

    // 1: reset held for 5 cycles with trig_i toggling.
    any_out = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      any_out = any_out | int'(pulse0) | int'(busy0) | int'(done0) | int'(miss0)
                        | int'(pulse1) | int'(busy1) | int'(done1) | int'(miss1);
      trig0 = (i % 2 == 0) && (i < 4);
      trig1 = trig0;
    end
    check("reset_outputs", any_out, 0);
    rstn0 = 1'b1; rstn1 = 1'b1; trig0 = 1'b0; trig1 = 1'b0;
    @(negedge clk);
    check("post_reset_pulse", int'(pulse0), 0);
    check("post_reset_busy",  int'(busy0),  0);
    check("post_reset_done",  int'(done0),  0);
    check("post_reset_miss",  int'(miss0),  0);

    // 2: single pulse, width=3 period=5 count=1; config changed mid-train.
    set_cfg(3, 5, 1);
    run_window(0, 26, -1, -1, -1, -1, 2, -1, 1'b1, 1'b0, 1'b0);
    check("single_first_hi", rise_idx[0], 1);
    check("single_n_hi",     n_hi,        12);
    check("single_last_hi",  last_hi,     12);
    check("single_n_busy",   n_busy,      20);
    check("single_last_busy", last_busy,  20);
    check("single_done_idx", done_idx,    21);
    check("single_n_done",   n_done,      1);
    check("single_n_miss",   n_miss,      0);

    // 3: train width=1 period=2 count=3 with triggers while busy.
    set_cfg(1, 2, 3);
    run_window(0, 30, 3, 10, 18, -1, -1, -1, 1'b1, 1'b0, 1'b0);
    check("train_n_rise", n_rise,      3);
    check("train_rise0",  rise_idx[0], 1);
    check("train_rise1",  rise_idx[1], 9);
    check("train_rise2",  rise_idx[2], 17);
    check("train_n_hi",   n_hi,        12);
    check("train_n_miss", n_miss,      3);
    check("train_miss0",  miss_idx[0], 4);
    check("train_miss1",  miss_idx[1], 11);
    check("train_miss2",  miss_idx[2], 19);
    check("train_last_busy", last_busy, 24);
    check("train_done_idx", done_idx,  25);

    // 3b: trigger in the cycle busy_o falls is missed, no retrigger.
    set_cfg(1, 2, 1);
    run_window(0, 16, 8, -1, -1, -1, -1, -1, 1'b1, 1'b0, 1'b0);
    check("fall_done_idx", done_idx,    9);
    check("fall_n_miss",   n_miss,      1);
    check("fall_miss_idx", miss_idx[0], 9);
    check("fall_n_rise",   n_rise,      1);

    // 4a: count=0 gives exactly one pulse.
    set_cfg(1, 2, 0);
    run_window(0, 14, -1, -1, -1, -1, -1, -1, 1'b1, 1'b0, 1'b0);
    check("cnt0_n_rise",   n_rise,   1);
    check("cnt0_n_hi",     n_hi,     4);
    check("cnt0_done_idx", done_idx, 9);

    // 4b: width=0 gives no pulse and done_o one cycle after the trigger.
    set_cfg(0, 5, 3);
    run_window(0, 6, -1, -1, -1, -1, -1, -1, 1'b1, 1'b0, 1'b0);
    check("w0_n_hi",     n_hi,     0);
    check("w0_n_busy",   n_busy,   0);
    check("w0_done_idx", done_idx, 1);
    check("w0_n_done",   n_done,   1);

    // 4c: width=5 period=2 -> period_eff=6, LOW = 4 cycles.
    set_cfg(5, 2, 1);
    run_window(0, 28, -1, -1, -1, -1, -1, -1, 1'b1, 1'b0, 1'b0);
    check("wide_n_hi",      n_hi,      20);
    check("wide_last_hi",   last_hi,   20);
    check("wide_last_busy", last_busy, 24);
    check("wide_done_idx",  done_idx,  25);

    // Trigger while disarmed is ignored.
    arm = 1'b0;
    set_cfg(1, 2, 1);
    run_window(0, 10, -1, -1, -1, -1, -1, -1, 1'b1, 1'b0, 1'b0);
    check("disarm_n_busy", n_busy, 0);
    check("disarm_n_done", n_done, 0);
    arm = 1'b1;

    // Abort together with trigger in IDLE: abort wins, nothing happens.
    run_window(0, 10, -1, -1, -1, -1, -1, -1, 1'b1, 1'b1, 1'b0);
    check("abtrig_n_busy", n_busy, 0);
    check("abtrig_n_done", n_done, 0);
    check("abtrig_n_miss", n_miss, 0);

    // 5: abort mid-HIGH of pulse 2, then a fresh train with new config.
    set_cfg(2, 4, 4);
    run_window(0, 20, -1, -1, -1, 18, -1, -1, 1'b1, 1'b0, 1'b0);
    check("abort_n_rise",    n_rise,      2);
    check("abort_rise1",     rise_idx[1], 17);
    check("abort_last_hi",   last_hi,     18);
    check("abort_last_busy", last_busy,   18);
    check("abort_done_idx",  done_idx,    19);
    check("abort_n_done",    n_done,      1);
    @(negedge clk);
    set_cfg(1, 3, 1);
    run_window(0, 16, -1, -1, -1, -1, -1, -1, 1'b1, 1'b0, 1'b0);
    check("reabort_rise0",     rise_idx[0], 1);
    check("reabort_last_hi",   last_hi,     4);
    check("reabort_last_busy", last_busy,   12);
    check("reabort_done_idx",  done_idx,    13);

    // 6: reset mid-train on the DIV=1 instance drops pulse_o, no done_o.
    set_cfg(2, 3, 5);
    run_window(1, 12, -1, -1, -1, -1, -1, 4, 1'b1, 1'b0, 1'b0);
    check("rst_n_rise",    n_rise,    2);
    check("rst_last_hi",   last_hi,   4);
    check("rst_last_busy", last_busy, 4);
    check("rst_n_done",    n_done,    0);

`ifdef PULSE_GEN_INVERT_EN
    // Inverted output: low during HIGH phases, high afterwards.
    inv = 1'b1;
    set_cfg(1, 2, 1);
    run_window(0, 12, -1, -1, -1, -1, -1, -1, 1'b1, 1'b0, 1'b1);
    check("inv_n_hi",     n_hi,     4);
    check("inv_done_idx", done_idx, 9);
    check("inv_idle_lvl", last_raw, 1);
    inv = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
